imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Drives the 12-bit address into the synchronous IMem ROM and absorbs its one-cycle read latency.
- Buffers the returned 16-bit words in a small FIFO tagged with their PC, and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush, and a halt input.

Parameters:
- ADDR_W, 12: IMem address width; PC width.
- DATA_W, 16: instruction width.
- RESET_PC, 0: first fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, minimum 2.

Ports:
- clock  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- imem_address  out  ADDR_W: address to IMem; sampled by IMem on clock rise.
- imem_q  in  DATA_W: IMem data, valid the cycle after the address edge.
- redirect_valid  in  1: load new PC this cycle.
- redirect_pc  in  ADDR_W: target PC.
- halt  in  1: suppress new fetch issue.
- instr_valid  out  1: instr_data/instr_pc valid.
- instr_data  out  DATA_W: fetched instruction.
- instr_pc  out  ADDR_W: address of instr_data.
- instr_ready  in  1: decode accepts; transfer = instr_valid & instr_ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset values:
  - pc = RESET_PC, imem_address = RESET_PC.
  - FIFO empty; instr_valid = 0; instr_data = 0, instr_pc = 0.
  - No fetch in flight; epoch = 0.
- imem_address is combinational: redirect_valid ? redirect_pc : pc.
- Issue condition, evaluated each cycle:
  - issue = !halt & ((count + inflight − pop) < FIFO_DEPTH), where pop = instr_valid & instr_ready.
  - On issue: pc <= imem_address + 1, modulo 2^ADDR_W (0xFFF wraps to 0x000).
  - On issue: inflight <= 1, inflight_pc <= imem_address, inflight_epoch <= epoch (post-redirect value).
  - No issue: pc holds; inflight <= 0.
- Capture: in the cycle after an issue, if inflight_epoch == epoch, push {inflight_pc, imem_q} into the FIFO. Otherwise drop it.
- Throughput: one instruction per cycle sustained while decode keeps instr_ready = 1.
- Latency: reset release or redirect to instr_valid = 1 is 2 clock edges.
  - Edge 1: address registered by IMem.
  - Edge 2: FIFO write.
- FIFO behaviour:
  - instr_valid = !empty; head driven registered from storage.
  - Push and pop in the same cycle are both honoured.
  - Full is never overrun, because the credit check reserves a slot per in-flight fetch.
- Redirect (redirect_valid = 1):
  - FIFO cleared at the edge; a simultaneous pop is ignored.
  - epoch toggles, so the in-flight word returning next cycle is discarded.
  - Redirect target is issued in the same cycle unless halt = 1; the issue check uses count = 0.
  - If halt = 1: pc <= redirect_pc and nothing is issued.
- Halt:
  - Stops new issue only.
  - A fetch already in flight is still captured.
  - FIFO contents still drain to decode.
- Reset asserted mid-operation: immediate return to reset values; any in-flight data is dropped.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra output ports, each 32 bits:
  - perf_fetches: counts captured (non-dropped) words.
  - perf_bubbles: counts cycles with !halt & !instr_valid.
  - Both reset to 0 and wrap at 2^32.
  - Both clear on redirect_valid = 0? No: redirect does not clear them.
- When not defined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Common setup: bench IMem model returns q = {4'hA, addr} one cycle after the address edge.
- Reset release with instr_ready = 1 -> imem_address 0x000, 0x001, 0x002… one per cycle. First instr_valid after 2 edges with instr_pc = 0x000, instr_data = 0xA000. Then consecutive PCs with no bubbles.
- instr_ready = 0 for 10 cycles -> exactly 4 entries buffered (0x000–0x003), issue stops, pc = 0x004. On ready = 1, entries drain in order and fetch of 0x004 resumes with no gap or duplicate.
- Redirect to 0x123 while FIFO holds 3 entries and a fetch is in flight -> FIFO empties, old word is dropped. Next delivered is instr_pc = 0x123, data 0xA123, 2 edges after redirect.
- RESET_PC = 0xFFE, free-running -> delivered PCs 0xFFE, 0xFFF, 0x000, 0x001.
- halt = 1 one cycle after an issue -> the in-flight word is still delivered, then instr_valid = 0. halt = 0 resumes at the next sequential PC.
- FETCH_PERF_EN defined: 5 delivered instructions plus 2 idle non-halt cycles -> perf_fetches = 5, perf_bubbles = 2 (the 2 startup cycles are counted).

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction fetch initiator: drives the synchronous IMem ROM, absorbs its one-cycle latency and
// buffers PC-tagged words for decode. Optional perf counters are enabled with `FETCH_PERF_EN.
module imem_fetch_unit #(
  parameter int unsigned        ADDR_W     = 12,
  parameter int unsigned        DATA_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_PERF_EN
  input  logic              instr_ready,
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_bubbles
`else
  input  logic              instr_ready
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_epoch_q, inflight_epoch_d;

  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_eff;
  int unsigned       credit;

  assign imem_address = redirect_valid ? redirect_pc : pc_q;

  assign instr_valid = (count_q != '0);
  assign instr_data  = data_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];

  // A redirect flushes the buffer, so a same-cycle pop is void and the credit check sees it empty.
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid;

  always_comb begin
    count_eff = redirect_valid ? '0 : count_q;
    credit    = 32'(count_eff) + 32'(inflight_q) - 32'(pop);
    issue     = !halt && (credit < FIFO_DEPTH);
  end

  always_comb begin
    epoch_d          = epoch_q ^ redirect_valid;
    pc_d             = pc_q;
    inflight_d       = issue;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    if (issue) begin
      pc_d             = imem_address + {{(ADDR_W-1){1'b0}}, 1'b1};
      inflight_pc_d    = imem_address;
      inflight_epoch_d = epoch_d;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  always_comb begin
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_mem_d[wr_ptr_q] = imem_q;
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      data_mem_q       <= '{default: '0};
      pc_mem_q         <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      data_mem_q       <= data_mem_d;
      pc_mem_q         <= pc_mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q + 32'(push);
    perf_bubbles_d = perf_bubbles_q + 32'(!halt && !instr_valid);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetches_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed phases push expected {pc, data} entries and
// negedge monitors compare every decode transfer in order.
module tb_imem_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] imem_address, imem_address2;
  logic [15:0] imem_q = '0, imem_q2 = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        instr_valid, instr_valid2;
  logic [15:0] instr_data, instr_data2;
  logic [11:0] instr_pc, instr_pc2;
  logic        instr_ready = 1'b1;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_bubbles, perf_fetches2, perf_bubbles2;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [27:0] exp_q[$];
  logic [27:0] exp2_q[$];
  logic [27:0] mon_e, mon2_e;

  always #5 clock = ~clock;

  imem_fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_address  (imem_address),
    .imem_q        (imem_q),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
`ifdef FETCH_PERF_EN
    .instr_ready   (instr_ready),
    .perf_fetches  (perf_fetches),
    .perf_bubbles  (perf_bubbles)
`else
    .instr_ready   (instr_ready)
`endif
  );

  imem_fetch_unit #(.RESET_PC(12'hFFE)) dut_wrap (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_address  (imem_address2),
    .imem_q        (imem_q2),
    .redirect_valid(1'b0),
    .redirect_pc   (12'h000),
    .halt          (1'b0),
    .instr_valid   (instr_valid2),
    .instr_data    (instr_data2),
    .instr_pc      (instr_pc2),
`ifdef FETCH_PERF_EN
    .instr_ready   (1'b1),
    .perf_fetches  (perf_fetches2),
    .perf_bubbles  (perf_bubbles2)
`else
    .instr_ready   (1'b1)
`endif
  );

  // IMem models: q = {4'hA, addr} one cycle after the address edge.
  always @(posedge clock) begin
    imem_q  <= {4'hA, imem_address};
    imem_q2 <= {4'hA, imem_address2};
  end

  function automatic logic [27:0] ent(input logic [11:0] pc);
    return {pc, 4'hA, pc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset at the current point, checks reset values, releases at the start of cycle 0.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_data", 32'(instr_data), 0);
    check("rst_pc", 32'(instr_pc), 0);
    check("rst_addr", 32'(imem_address), 0);
    check("rst_addr_wrapdut", 32'(imem_address2), 32'h0FFE);
    step();
    step();
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_xfer: got pc 0x%0h data 0x%0h, expected no transfer",
                 instr_pc, instr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_pc", 32'(instr_pc), 32'(mon_e[27:16]));
        check("xfer_data", 32'(instr_data), 32'(mon_e[15:0]));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && instr_valid2 && exp2_q.size() != 0) begin
      mon2_e = exp2_q.pop_front();
      check("wrap_pc", 32'(instr_pc2), 32'(mon2_e[27:16]));
      check("wrap_data", 32'(instr_data2), 32'(mon2_e[15:0]));
    end
  end

  initial begin
    exp2_q.push_back(ent(12'hFFE));
    exp2_q.push_back(ent(12'hFFF));
    exp2_q.push_back(ent(12'h000));
    exp2_q.push_back(ent(12'h001));
    step();
    do_reset();

    // Free-running fetch: address increments each cycle, first valid at cycle 2.
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(12'(i)));
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("a_addr", 32'(imem_address), 32'(c));
      check("a_valid", 32'(instr_valid), 32'(c >= 2));
      step();
    end
    check("a_drained", 32'(exp_q.size()), 0);

    // Back-pressure: buffer fills to 4 entries, issue stops at pc 0x004, then drains gap-free.
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("b_addr", 32'(imem_address), (c < 4) ? 32'(c) : 32'd4);
      if (c == 9) begin
        check("b_full_valid", 32'(instr_valid), 1);
        check("b_head_pc", 32'(instr_pc), 0);
      end
      step();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(12'(i)));
    for (int c = 10; c < 18; c++) begin
      @(negedge clock);
      check("b_stream_valid", 32'(instr_valid), 1);
      step();
    end
    check("b_drained", 32'(exp_q.size()), 0);

    // Redirect with 3 buffered entries and a fetch in flight.
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h123;
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(12'h123 + 12'(i)));
    @(negedge clock);
    check("c_addr", 32'(imem_address), 32'h123);
    check("c_pre_valid", 32'(instr_valid), 1);
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    for (int c = 5; c < 9; c++) begin
      @(negedge clock);
      check("c_valid", 32'(instr_valid), 32'(c >= 6));
      step();
    end
    check("c_drained", 32'(exp_q.size()), 0);

    // Halt one cycle after the first issue; in-flight word still delivered.
    do_reset();
    exp_q.push_back(ent(12'h000));
    step();
    halt = 1'b1;
    for (int c = 1; c < 6; c++) begin
      @(negedge clock);
      check("d_halt_valid", 32'(instr_valid), 32'(c == 2));
      check("d_halt_addr", 32'(imem_address), 1);
      step();
    end
    halt = 1'b0;
    exp_q.push_back(ent(12'h001));
    exp_q.push_back(ent(12'h002));
    for (int c = 6; c < 10; c++) begin
      @(negedge clock);
      check("d_resume_valid", 32'(instr_valid), 32'(c >= 8));
      step();
    end
    check("d_drained", 32'(exp_q.size()), 0);

    // Five deliveries then halt: two startup bubbles only.
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(ent(12'(i)));
    for (int c = 0; c < 5; c++) step();
    halt = 1'b1;
    for (int c = 5; c < 10; c++) begin
      @(negedge clock);
      check("e_valid", 32'(instr_valid), 32'(c <= 6));
      step();
    end
    check("e_drained", 32'(exp_q.size()), 0);
`ifdef FETCH_PERF_EN
    check("perf_fetches", perf_fetches, 5);
    check("perf_bubbles", perf_bubbles, 2);
`endif

    check("wrap_drained", 32'(exp2_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
